// File: rtl/mux_arb_pkg.sv
// Shared definitions for the virtual-channel mux/arbiter.
//   arb_mode_e : arbitration policy encodings (fixed priority / round-robin)
//   idx_width  : bit width needed to hold an index in 0..n-1 (at least 1)
package mux_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arb_vc_rr_arbiter.sv
// rr_arbiter: one-hot request arbiter with fixed-priority and round-robin modes.
// Ports:
//   clk, reset_L : clock, asynchronous active-low reset
//   req          : per-requester request vector
//   enable       : when low, no grant is issued
//   mode         : ARB_FIXED (lowest index wins) or ARB_RR (rotating start)
//   grant        : combinational one-hot grant, all-zero when nothing wins
// The last_grant register resets to NUM_REQ-1 so requester 0 is searched
// first after reset, and it only moves on cycles that produce a grant.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  arb_mode_e          mode,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      start_idx;
  logic [IW-1:0]      grant_idx;
  logic               found;
  int unsigned        cand;
  logic [NUM_REQ-1:0] cand_oh;

  always_comb begin
    if (mode == ARB_RR) begin
      start_idx = (last_grant == IW'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;
    end else begin
      start_idx = '0;
    end
  end

  // Scan NUM_REQ candidates starting at start_idx, wrapping past the top;
  // the first requesting candidate wins.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = 0;
    cand_oh   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = int'(start_idx) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_oh = NUM_REQ'(1) << cand;
      if (!found && enable && (|(req & cand_oh))) begin
        found     = 1'b1;
        grant     = cand_oh;
        grant_idx = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      last_grant <= IW'(NUM_REQ - 1);
    end else if (found) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/mux_arb_vc.sv
// mux_arb_vc: arbitrates NUM_VC upstream FIFOs onto one registered output.
// Ports:
//   clk             : clock, rising edge
//   reset_L         : asynchronous active-low reset
//   fifo_empty      : per-channel empty flags
//   fifo_data       : packed read data, channel i at [i*DATA_SIZE +: DATA_SIZE],
//                     valid the cycle after that channel is popped
//   dst_almost_full : back-pressure, blocks new pops only
//   pop             : combinational one-hot pop request
//   data_out        : registered selected word (zero when idle)
//   valid_out       : registered, one cycle per delivered word
//   grant_vc        : registered channel index of data_out (held when idle)
// Pipeline: pop (cycle t) -> pop_d (t+1, FIFO data valid) -> outputs (t+2).
module mux_arb_vc
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 6,
  parameter int unsigned NUM_VC    = 4,
  parameter int unsigned ARB_MODE  = 1
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [NUM_VC-1:0]             fifo_empty,
  input  logic [NUM_VC*DATA_SIZE-1:0]   fifo_data,
  input  logic                          dst_almost_full,
  output logic [NUM_VC-1:0]             pop,
  output logic [DATA_SIZE-1:0]          data_out,
  output logic                          valid_out,
  output logic [idx_width(NUM_VC)-1:0]  grant_vc
);

  localparam int unsigned IW   = idx_width(NUM_VC);
  localparam arb_mode_e   MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

  logic [NUM_VC-1:0]    eligible;
  logic [NUM_VC-1:0]    pop_d;
  logic [IW-1:0]        sel_idx;
  logic [DATA_SIZE-1:0] sel_data;

  assign eligible = ~fifo_empty & {NUM_VC{~dst_almost_full}};

  // Gating enable with reset_L keeps pop quiet while reset is held.
  rr_arbiter #(
    .NUM_REQ (NUM_VC)
  ) u_arb (
    .clk     (clk),
    .reset_L (reset_L),
    .req     (eligible),
    .enable  (reset_L),
    .mode    (MODE),
    .grant   (pop)
  );

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (|(pop_d & (NUM_VC'(1) << i))) begin
        sel_idx  = IW'(i);
        sel_data = DATA_SIZE'(fifo_data >> (i * DATA_SIZE));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_d     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      grant_vc  <= '0;
    end else begin
      pop_d <= pop;
      if (|pop_d) begin
        data_out  <= sel_data;
        grant_vc  <= sel_idx;
        valid_out <= 1'b1;
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_vc.sv
// Directed bench for mux_arb_vc: a round-robin instance and a fixed-priority
// instance share all inputs; expected values are written out per cycle.
module tb_mux_arb_vc;

  logic        clk;
  logic        reset_L;
  logic [3:0]  fifo_empty;
  logic [23:0] fifo_data;
  logic        dst_almost_full;

  logic [3:0]  pop_r, pop_f;
  logic [5:0]  data_r, data_f;
  logic        valid_r, valid_f;
  logic [1:0]  grant_r, grant_f;

  int n_total;
  int n_pass;
  int n_fail;

  mux_arb_vc #(.DATA_SIZE(6), .NUM_VC(4), .ARB_MODE(1)) dut_rr (
    .clk             (clk),
    .reset_L         (reset_L),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .dst_almost_full (dst_almost_full),
    .pop             (pop_r),
    .data_out        (data_r),
    .valid_out       (valid_r),
    .grant_vc        (grant_r)
  );

  mux_arb_vc #(.DATA_SIZE(6), .NUM_VC(4), .ARB_MODE(0)) dut_fix (
    .clk             (clk),
    .reset_L         (reset_L),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .dst_almost_full (dst_almost_full),
    .pop             (pop_f),
    .data_out        (data_f),
    .valid_out       (valid_f),
    .grant_vc        (grant_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic [3:0] p, input logic v,
                         input logic [1:0] g, input logic [5:0] d);
    chk({tag, ".pop"},   32'(pop_r),   32'(p));
    chk({tag, ".valid"}, 32'(valid_r), 32'(v));
    chk({tag, ".grant"}, 32'(grant_r), 32'(g));
    chk({tag, ".data"},  32'(data_r),  32'(d));
  endtask

  // Channel i word is 0x10+i, except channel 2 which is driven by d2.
  task automatic step(input logic rst, input logic [3:0] emp, input logic daf,
                      input logic [5:0] d2);
    @(posedge clk);
    #1;
    reset_L         = rst;
    fifo_empty      = emp;
    dst_almost_full = daf;
    fifo_data       = {6'h13, d2, 6'h11, 6'h10};
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    reset_L         = 1'b0;
    fifo_empty      = 4'b0000;
    dst_almost_full = 1'b0;
    fifo_data       = {6'h13, 6'h12, 6'h11, 6'h10};
    #3;
    exp_out("reset", 4'b0000, 1'b0, 2'd0, 6'h00);
    chk("reset.fix_pop", 32'(pop_f), 32'd0);

    // Round-robin stream, all channels non-empty.
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 4'b0000, 1'b0, 6'h12);
      if (c < 2) exp_out("rr_stream", 4'(1 << (c % 4)), 1'b0, 2'd0, 6'h00);
      else exp_out("rr_stream", 4'(1 << (c % 4)), 1'b1, 2'(c - 2), 6'h10 + 6'((c - 2) % 4));
      chk("fix_stream.pop", 32'(pop_f), 32'd1);
    end

    // All empty: drain then idle.
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("empty0", 4'b0000, 1'b1, 2'd2, 6'h12);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("empty1", 4'b0000, 1'b1, 2'd3, 6'h13);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("empty2", 4'b0000, 1'b0, 2'd3, 6'h00);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("empty3", 4'b0000, 1'b0, 2'd3, 6'h00);
    chk("empty.fix_pop", 32'(pop_f), 32'd0);

    // Channels 1 and 3 non-empty.
    step(1'b1, 4'b0101, 1'b0, 6'h12); exp_out("ch13_0", 4'b0010, 1'b0, 2'd3, 6'h00);
    chk("ch13_0.fix_pop", 32'(pop_f), 32'b0010);
    step(1'b1, 4'b0101, 1'b0, 6'h12); exp_out("ch13_1", 4'b1000, 1'b0, 2'd3, 6'h00);
    chk("ch13_1.fix_pop", 32'(pop_f), 32'b0010);
    step(1'b1, 4'b0101, 1'b0, 6'h12); exp_out("ch13_2", 4'b0010, 1'b1, 2'd1, 6'h11);
    chk("ch13_2.fix_pop", 32'(pop_f), 32'b0010);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("ch13_3", 4'b0000, 1'b1, 2'd3, 6'h13);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("ch13_4", 4'b0000, 1'b1, 2'd1, 6'h11);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("ch13_5", 4'b0000, 1'b0, 2'd1, 6'h00);

    // Streaming with back-pressure raised on the sixth cycle (last_grant = 1).
    step(1'b1, 4'b0000, 1'b0, 6'h12); exp_out("bp0", 4'b0100, 1'b0, 2'd1, 6'h00);
    step(1'b1, 4'b0000, 1'b0, 6'h12); exp_out("bp1", 4'b1000, 1'b0, 2'd1, 6'h00);
    step(1'b1, 4'b0000, 1'b0, 6'h12); exp_out("bp2", 4'b0001, 1'b1, 2'd2, 6'h12);
    step(1'b1, 4'b0000, 1'b0, 6'h12); exp_out("bp3", 4'b0010, 1'b1, 2'd3, 6'h13);
    step(1'b1, 4'b0000, 1'b0, 6'h12); exp_out("bp4", 4'b0100, 1'b1, 2'd0, 6'h10);
    step(1'b1, 4'b0000, 1'b1, 6'h12); exp_out("bp5", 4'b0000, 1'b1, 2'd1, 6'h11);
    chk("bp5.fix_pop", 32'(pop_f), 32'd0);
    step(1'b1, 4'b0000, 1'b1, 6'h12); exp_out("bp6", 4'b0000, 1'b1, 2'd2, 6'h12);
    step(1'b1, 4'b0000, 1'b1, 6'h12); exp_out("bp7", 4'b0000, 1'b0, 2'd2, 6'h00);
    step(1'b1, 4'b0000, 1'b0, 6'h12); exp_out("bp8", 4'b1000, 1'b0, 2'd2, 6'h00);
    step(1'b1, 4'b0000, 1'b0, 6'h12); exp_out("bp9", 4'b0001, 1'b0, 2'd2, 6'h00);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("bp10", 4'b0000, 1'b1, 2'd3, 6'h13);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("bp11", 4'b0000, 1'b1, 2'd0, 6'h10);

    // Reset while pop_d holds channel 2 carrying 0x2A.
    step(1'b1, 4'b1011, 1'b0, 6'h2A); exp_out("rst_mid0", 4'b0100, 1'b0, 2'd0, 6'h00);
    step(1'b0, 4'b1011, 1'b0, 6'h2A); exp_out("rst_mid1", 4'b0000, 1'b0, 2'd0, 6'h00);
    step(1'b0, 4'b0000, 1'b0, 6'h2A); exp_out("rst_mid2", 4'b0000, 1'b0, 2'd0, 6'h00);
    chk("rst_mid2.fix_pop", 32'(pop_f), 32'd0);
    step(1'b1, 4'b0000, 1'b0, 6'h2A); exp_out("rst_rel0", 4'b0001, 1'b0, 2'd0, 6'h00);
    chk("rst_rel0.fix_pop", 32'(pop_f), 32'b0001);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("rst_rel1", 4'b0000, 1'b0, 2'd0, 6'h00);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("rst_rel2", 4'b0000, 1'b1, 2'd0, 6'h10);
    step(1'b1, 4'b1111, 1'b0, 6'h12); exp_out("rst_rel3", 4'b0000, 1'b0, 2'd0, 6'h00);

    // Only channel 2 non-empty; its FIFO presents 0x01..0x05 after each pop.
    step(1'b1, 4'b1011, 1'b0, 6'h3F); exp_out("ch2_0", 4'b0100, 1'b0, 2'd0, 6'h00);
    step(1'b1, 4'b1011, 1'b0, 6'h01); exp_out("ch2_1", 4'b0100, 1'b0, 2'd0, 6'h00);
    step(1'b1, 4'b1011, 1'b0, 6'h02); exp_out("ch2_2", 4'b0100, 1'b1, 2'd2, 6'h01);
    step(1'b1, 4'b1011, 1'b0, 6'h03); exp_out("ch2_3", 4'b0100, 1'b1, 2'd2, 6'h02);
    step(1'b1, 4'b1011, 1'b0, 6'h04); exp_out("ch2_4", 4'b0100, 1'b1, 2'd2, 6'h03);
    step(1'b1, 4'b1111, 1'b0, 6'h05); exp_out("ch2_5", 4'b0000, 1'b1, 2'd2, 6'h04);
    step(1'b1, 4'b1111, 1'b0, 6'h00); exp_out("ch2_6", 4'b0000, 1'b1, 2'd2, 6'h05);
    step(1'b1, 4'b1111, 1'b0, 6'h00); exp_out("ch2_7", 4'b0000, 1'b0, 2'd2, 6'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
